// File: rtl/axi_hp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_pkg
// Purpose  : Shared widths, AXI3 encodings, FSM state types and the address
//            and burst check used by the S_AXI_HP responder.
// Revision : 1.0  initial release
// ============================================================================
package axi_hp_pkg;

    localparam int ID_W   = 6;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_64 = 3'b011;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Response for a whole burst from its address phase; SLVERR wins over DECERR.
    function automatic logic [1:0] burst_resp(
        input logic [31:0]      addr,
        input logic [LEN_W-1:0] len,
        input logic [2:0]       size,
        input logic [1:0]       burst,
        input logic [31:0]      base,
        input int unsigned      aw
    );
        logic [32:0] off;
        logic [31:0] first_word;
        logic [31:0] last_word;
        logic        oob;
        off        = {1'b0, addr} - {1'b0, base};
        first_word = {3'b000, off[31:3]};
        last_word  = first_word + {{(32-LEN_W){1'b0}}, len};
        oob        = off[32] || (last_word >= (32'd1 << aw));
        if (size != SIZE_64 || burst != BURST_INCR) begin
            return RESP_SLVERR;
        end else if (oob) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_hp_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_resp_ram
// Purpose  : Simple dual-port RAM, byte-enabled write port and registered
//            read-first read port.
// Revision : 1.0  initial release
// ============================================================================
module axi_hp_resp_ram
    import axi_hp_pkg::*;
#(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = DATA_W
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    localparam int unsigned c_lanes = DW / 8;
    localparam int unsigned c_depth = 1 << AW;

    // One narrow array per byte lane keeps the byte enables a plain write enable.
    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        logic [7:0] r_mem [c_depth];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (re) begin
                r_q <= r_mem[raddr];
            end
            if (we && wstrb[g]) begin
                r_mem[waddr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/axi_hp_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_hp_responder
// Purpose  : AXI3 slave modelled on the Zynq S_AXI_HP port, backed by on-chip
//            RAM, with independent single-burst read and write engines.
// Revision : 1.0  initial release
// ============================================================================
module axi_hp_responder
    import axi_hp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MEM_AW    = 12,
    parameter int unsigned RD_WAIT   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [31:0]       s_axi_araddr,
    input  logic [LEN_W-1:0]  s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [1:0]        s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    input  logic [3:0]        s_axi_arqos,

    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic              s_axi_rlast,

    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_awaddr,
    input  logic [LEN_W-1:0]  s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [1:0]        s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic [3:0]        s_axi_awqos,

    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic [ID_W-1:0]   s_axi_wid,
    input  logic              s_axi_wlast,

    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    output logic [ID_W-1:0]   s_axi_bid
);

    localparam int unsigned        c_wait_w = $clog2(RD_WAIT + 2);
    localparam logic [c_wait_w-1:0] c_wait_load = c_wait_w'(RD_WAIT + 1);
    localparam logic [MEM_AW-1:0]  c_addr_one = MEM_AW'(1);
    localparam logic [LEN_W-1:0]   c_len_one  = LEN_W'(1);

    // ------------------------------------------------------------ read side
    rd_state_t           r_rstate;
    logic                r_arready;
    logic                r_rvalid;
    logic                r_rlast;
    logic [1:0]          r_rresp;
    logic [ID_W-1:0]     r_rid;
    logic [MEM_AW-1:0]   r_raddr;
    logic [LEN_W-1:0]    r_rlen;
    logic [LEN_W-1:0]    r_rbeat;
    logic [c_wait_w-1:0] r_rwait;

    logic                w_ar_hs;
    logic                w_r_hs;
    logic [1:0]          w_ar_resp;
    logic [MEM_AW-1:0]   w_ar_word;
    logic                w_rd_en;
    logic [MEM_AW-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   w_ram_q;

    assign w_ar_hs   = s_axi_arvalid && r_arready;
    assign w_r_hs    = r_rvalid && s_axi_rready;
    assign w_ar_resp = burst_resp(s_axi_araddr, s_axi_arlen, s_axi_arsize,
                                  s_axi_arburst, BASE_ADDR, MEM_AW);
    assign w_ar_word = MEM_AW'((s_axi_araddr - BASE_ADDR) >> 3);

    // The last wait cycle loads the first word; each accepted beat loads the next.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_raddr;
        if (r_rresp == RESP_OKAY) begin
            if (r_rstate == R_WAIT && r_rwait == '0) begin
                w_rd_en = 1'b1;
            end else if (r_rstate == R_DATA && w_r_hs && !r_rlast) begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_raddr + c_addr_one;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rwait   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_raddr   <= w_ar_word;
                        r_rlen    <= s_axi_arlen;
                        r_rid     <= s_axi_arid;
                        r_rresp   <= w_ar_resp;
                        r_rbeat   <= '0;
                        r_rwait   <= c_wait_load;
                        r_rstate  <= R_WAIT;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_rwait == '0) begin
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_rlen == '0);
                        r_rstate <= R_DATA;
                    end else begin
                        r_rwait <= r_rwait - c_wait_w'(1);
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + c_len_one;
                            r_raddr <= r_raddr + c_addr_one;
                            r_rlast <= ((r_rbeat + c_len_one) == r_rlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rid     = r_rid;
    // Error bursts and idle cycles present zero instead of stale RAM output.
    assign s_axi_rdata   = (r_rvalid && r_rresp == RESP_OKAY) ? w_ram_q : '0;

    // ----------------------------------------------------------- write side
    wr_state_t         r_wstate;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_wresp;
    logic [MEM_AW-1:0] r_waddr;
    logic [LEN_W-1:0]  r_wlen;
    logic [LEN_W-1:0]  r_wbeat;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic [1:0]        w_aw_resp;
    logic [MEM_AW-1:0] w_aw_word;
    logic              w_beat_last;
    logic              w_beat_bad;
    logic [1:0]        w_beat_resp;
    logic              w_w_end;
    logic              w_we;

    assign w_aw_hs     = s_axi_awvalid && r_awready;
    assign w_w_hs      = s_axi_wvalid && r_wready;
    assign w_aw_resp   = burst_resp(s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                                    s_axi_awburst, BASE_ADDR, MEM_AW);
    assign w_aw_word   = MEM_AW'((s_axi_awaddr - BASE_ADDR) >> 3);
    assign w_beat_last = (r_wbeat == r_wlen);
    // wlast must coincide exactly with beat awlen; either mismatch direction is an error.
    assign w_beat_bad  = (s_axi_wid != r_bid) || (s_axi_wlast != w_beat_last);
    assign w_beat_resp = w_beat_bad ? RESP_SLVERR : r_wresp;
    assign w_w_end     = w_w_hs && (s_axi_wlast || w_beat_last);
    assign w_we        = w_w_hs && (w_beat_resp == RESP_OKAY) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_bid     <= '0;
            r_wresp   <= RESP_OKAY;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_waddr   <= w_aw_word;
                        r_wlen    <= s_axi_awlen;
                        r_bid     <= s_axi_awid;
                        r_wresp   <= w_aw_resp;
                        r_wbeat   <= '0;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wresp <= w_beat_resp;
                        r_waddr <= r_waddr + c_addr_one;
                        r_wbeat <= r_wbeat + c_len_one;
                        if (w_w_end) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_beat_resp;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_bid;

    axi_hp_resp_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (w_we),
        .waddr (r_waddr),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (w_rd_en),
        .raddr (w_rd_addr),
        .rdata (w_ram_q)
    );

    logic w_unused;
    assign w_unused = ^{s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                        s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};

endmodule
`default_nettype wire

// File: tb/tb_axi_hp_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_hp_responder
// Purpose  : Directed, table-driven check of the S_AXI_HP RAM responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_hp_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TMO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 0, arready;
    logic [31:0] araddr = 0;
    logic [3:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic [1:0]  arburst = 0;
    logic [5:0]  arid = 0;
    logic        rvalid, rready = 0, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [5:0]  rid;
    logic        awvalid = 0, awready;
    logic [31:0] awaddr = 0;
    logic [3:0]  awlen = 0;
    logic [2:0]  awsize = 0;
    logic [1:0]  awburst = 0;
    logic [5:0]  awid = 0;
    logic        wvalid = 0, wready, wlast = 0;
    logic [63:0] wdata = 0;
    logic [7:0]  wstrb = 0;
    logic [5:0]  wid = 0;
    logic        bvalid, bready = 0;
    logic [1:0]  bresp;
    logic [5:0]  bid;

    always #5 clk = ~clk;

    axi_hp_responder #(
        .BASE_ADDR (BASE),
        .MEM_AW    (12),
        .RD_WAIT   (0)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .s_axi_arvalid (arvalid), .s_axi_arready (arready), .s_axi_araddr (araddr),
        .s_axi_arlen (arlen), .s_axi_arsize (arsize), .s_axi_arburst (arburst),
        .s_axi_arid (arid), .s_axi_arlock (2'b00), .s_axi_arcache (4'h3),
        .s_axi_arprot (3'b000), .s_axi_arqos (4'h0),
        .s_axi_rvalid (rvalid), .s_axi_rready (rready), .s_axi_rdata (rdata),
        .s_axi_rresp (rresp), .s_axi_rid (rid), .s_axi_rlast (rlast),
        .s_axi_awvalid (awvalid), .s_axi_awready (awready), .s_axi_awaddr (awaddr),
        .s_axi_awlen (awlen), .s_axi_awsize (awsize), .s_axi_awburst (awburst),
        .s_axi_awid (awid), .s_axi_awlock (2'b00), .s_axi_awcache (4'h3),
        .s_axi_awprot (3'b000), .s_axi_awqos (4'h0),
        .s_axi_wvalid (wvalid), .s_axi_wready (wready), .s_axi_wdata (wdata),
        .s_axi_wstrb (wstrb), .s_axi_wid (wid), .s_axi_wlast (wlast),
        .s_axi_bvalid (bvalid), .s_axi_bready (bready), .s_axi_bresp (bresp),
        .s_axi_bid (bid)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic [5:0]  ridb [16];
    logic        rlst [16];
    int          rd_lat;
    logic [1:0]  got_bresp;
    logic [5:0]  got_bid;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
    } vec_t;
    vec_t tbl [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic to_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL timeout %s: got no handshake, required one within %0d cycles", name, TMO);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [5:0] id, input int nbeats);
        int n;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1;
        n = 0;
        while (!awready && n < TMO) begin tick(); n++; end
        if (n >= TMO) to_fail("awready");
        tick();
        awvalid = 0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wid = id; wlast = (i == nbeats - 1); wvalid = 1;
            n = 0;
            while (!wready && n < TMO) begin tick(); n++; end
            if (n >= TMO) to_fail("wready");
            tick();
        end
        wvalid = 0; wlast = 0;
        bready = 1;
        n = 0;
        while (!bvalid && n < TMO) begin tick(); n++; end
        if (n >= TMO) to_fail("bvalid");
        got_bresp = bresp;
        got_bid   = bid;
        tick();
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id, input bit stall);
        int          n;
        int          beats;
        int          cyc;
        bit          hold;
        logic [63:0] held;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1;
        n = 0;
        while (!arready && n < TMO) begin tick(); n++; end
        if (n >= TMO) to_fail("arready");
        tick();
        arvalid = 0;
        beats = 0; cyc = 0; rd_lat = -1; hold = 0; held = '0;
        while (beats <= int'(len) && cyc < TMO) begin
            rready = stall ? cyc[0] : 1'b1;
            if (rvalid && rd_lat < 0) rd_lat = cyc;
            if (rvalid && rready) begin
                rbuf[beats] = rdata; rrsp[beats] = rresp; ridb[beats] = rid; rlst[beats] = rlast;
                beats++;
            end else if (rvalid) begin
                hold = 1; held = rdata;
            end
            tick();
            cyc++;
            if (hold) begin
                chk("r_stall_hold", rdata, held);
                hold = 0;
            end
        end
        if (cyc >= TMO) to_fail("rvalid");
        rready = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required end of test");
        $fatal(1);
    end

    initial begin
        int n;
        int beats;
        //            wr  addr             len   size  burst  data                      strb   resp   exp data
        tbl[0]  = '{1, BASE + 32'h40,   4'd0, 3'd3, 2'b01, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0};
        tbl[1]  = '{0, BASE + 32'h40,   4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b00, 64'h0123_4567_89AB_CDEF};
        tbl[2]  = '{1, BASE + 32'h80,   4'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'h0};
        tbl[3]  = '{1, BASE + 32'h80,   4'd0, 3'd3, 2'b01, 64'h0,                   8'h0F, 2'b00, 64'h0};
        tbl[4]  = '{0, BASE + 32'h80,   4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b00, 64'hFFFF_FFFF_0000_0000};
        tbl[5]  = '{0, BASE + 32'h40,   4'd0, 3'd2, 2'b01, 64'h0,                   8'h00, 2'b10, 64'h0};
        tbl[6]  = '{0, BASE + 32'h40,   4'd0, 3'd3, 2'b00, 64'h0,                   8'h00, 2'b10, 64'h0};
        tbl[7]  = '{1, BASE + 32'h7FF8, 4'd0, 3'd3, 2'b01, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 2'b00, 64'h0};
        tbl[8]  = '{1, BASE - 32'h8,    4'd0, 3'd3, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b11, 64'h0};
        tbl[9]  = '{0, BASE + 32'h7FF8, 4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b00, 64'hA5A5_A5A5_5A5A_5A5A};
        tbl[10] = '{0, BASE + 32'h7FF8, 4'd1, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b11, 64'h0};
        tbl[11] = '{0, BASE + 32'h8000, 4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b11, 64'h0};
        tbl[12] = '{1, BASE + 32'h43,   4'd0, 3'd3, 2'b01, 64'h1111_1111_1111_1111, 8'hFF, 2'b00, 64'h0};
        tbl[13] = '{0, BASE + 32'h40,   4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b00, 64'h1111_1111_1111_1111};
        tbl[14] = '{1, BASE + 32'h40,   4'd0, 3'd2, 2'b01, 64'h2222_2222_2222_2222, 8'hFF, 2'b10, 64'h0};
        tbl[15] = '{0, BASE + 32'h40,   4'd0, 3'd3, 2'b01, 64'h0,                   8'h00, 2'b00, 64'h1111_1111_1111_1111};
        tbl[16] = '{0, BASE - 32'h8,    4'd0, 3'd2, 2'b01, 64'h0,                   8'h00, 2'b10, 64'h0};

        // Reset values, then ready one cycle after release
        rst = 1;
        repeat (3) tick();
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_valids", {rvalid, bvalid, rlast}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids_resps", {rresp, rid, bresp, bid}, 0);
        rst = 0;
        tick();
        chk("rel_arready", arready, 1);
        chk("rel_awready", awready, 1);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                wbuf[0] = tbl[i].data;
                sbuf[0] = tbl[i].strb;
                axi_write(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 6'(i + 1), 1);
                chk($sformatf("tbl%0d_bresp", i), got_bresp, tbl[i].exp_resp);
                chk($sformatf("tbl%0d_bid", i), got_bid, 6'(i + 1));
            end else begin
                axi_read(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 6'(i + 1), 0);
                chk($sformatf("tbl%0d_lat", i), rd_lat, 2);
                for (int b = 0; b <= int'(tbl[i].len); b++) begin
                    chk($sformatf("tbl%0d_b%0d_rdata", i, b), rbuf[b], tbl[i].exp_data);
                    chk($sformatf("tbl%0d_b%0d_rresp", i, b), rrsp[b], tbl[i].exp_resp);
                    chk($sformatf("tbl%0d_b%0d_rid", i, b), ridb[b], 6'(i + 1));
                    chk($sformatf("tbl%0d_b%0d_rlast", i, b), rlst[b], b == int'(tbl[i].len));
                end
            end
        end

        // 16-beat burst, read back with rready toggling
        for (int i = 0; i < 16; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
        axi_write(BASE, 4'd15, 3'd3, 2'b01, 6'h05, 16);
        chk("burst_bresp", got_bresp, 2'b00);
        chk("burst_bid", got_bid, 6'h05);
        axi_read(BASE, 4'd15, 3'd3, 2'b01, 6'h09, 1);
        chk("burst_lat", rd_lat, 2);
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("burst_b%0d_rdata", b), rbuf[b], 64'(b));
            chk($sformatf("burst_b%0d_rlast", b), rlst[b], b == 15);
        end
        chk("burst_rid", ridb[15], 6'h09);
        chk("burst_arready_after", arready, 1);

        // Early wlast on beat 1 of a len=3 burst
        wbuf[0] = 64'h5555_5555_5555_5555; sbuf[0] = 8'hFF;
        axi_write(BASE + 32'h108, 4'd0, 3'd3, 2'b01, 6'h11, 1);
        wbuf[0] = 64'hBAD0; wbuf[1] = 64'hBAD1; sbuf[1] = 8'hFF;
        axi_write(BASE + 32'h100, 4'd3, 3'd3, 2'b01, 6'h12, 2);
        chk("early_wlast_bresp", got_bresp, 2'b10);
        chk("early_wlast_bid", got_bid, 6'h12);
        axi_read(BASE + 32'h108, 4'd0, 3'd3, 2'b01, 6'h13, 0);
        chk("early_wlast_ram", rbuf[0], 64'h5555_5555_5555_5555);

        // W presented before AW must wait, not be dropped
        wdata = 64'h00C0_FFEE_00C0_FFEE; wstrb = 8'hFF; wid = 6'h03; wlast = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("early_w_wready%0d", i), wready, 0);
        end
        awaddr = BASE + 32'h180; awlen = 0; awsize = 3'd3; awburst = 2'b01; awid = 6'h03; awvalid = 1;
        n = 0;
        while (!awready && n < TMO) begin tick(); n++; end
        tick();
        awvalid = 0;
        n = 0;
        while (!wready && n < TMO) begin tick(); n++; end
        if (n >= TMO) to_fail("early_w_wready");
        tick();
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (!bvalid && n < TMO) begin tick(); n++; end
        chk("early_w_bresp", bresp, 2'b00);
        tick();
        bready = 0;
        axi_read(BASE + 32'h180, 4'd0, 3'd3, 2'b01, 6'h14, 0);
        chk("early_w_ram", rbuf[0], 64'h00C0_FFEE_00C0_FFEE);

        // Same-edge write and read of one word returns the old data
        wbuf[0] = 64'h1111; sbuf[0] = 8'hFF;
        axi_write(BASE + 32'h200, 4'd0, 3'd3, 2'b01, 6'h15, 1);
        araddr = BASE + 32'h200; arlen = 0; arsize = 3'd3; arburst = 2'b01; arid = 6'h16; arvalid = 1;
        awaddr = BASE + 32'h200; awlen = 0; awsize = 3'd3; awburst = 2'b01; awid = 6'h17; awvalid = 1;
        chk("rw_both_ready", {arready, awready}, 2'b11);
        tick();
        arvalid = 0; awvalid = 0;
        tick();
        wdata = 64'h2222; wstrb = 8'hFF; wid = 6'h17; wlast = 1; wvalid = 1;
        tick();
        wvalid = 0; wlast = 0; rready = 1;
        chk("rw_rvalid", rvalid, 1);
        chk("rw_old_data", rdata, 64'h1111);
        tick();
        rready = 0; bready = 1;
        n = 0;
        while (!bvalid && n < TMO) begin tick(); n++; end
        chk("rw_bresp", bresp, 2'b00);
        tick();
        bready = 0;
        axi_read(BASE + 32'h200, 4'd0, 3'd3, 2'b01, 6'h18, 0);
        chk("rw_new_data", rbuf[0], 64'h2222);

        // Reset at beat 3 of a len=7 read
        araddr = BASE; arlen = 4'd7; arsize = 3'd3; arburst = 2'b01; arid = 6'h19; arvalid = 1;
        n = 0;
        while (!arready && n < TMO) begin tick(); n++; end
        tick();
        arvalid = 0; rready = 1;
        beats = 0; n = 0;
        while (beats < 3 && n < TMO) begin
            if (rvalid) beats++;
            tick();
            n++;
        end
        rready = 0;
        chk("rst_mid_beat3", rdata, 64'd3);
        rst = 1;
        tick();
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_arready", arready, 0);
        chk("rst_mid_rdata", rdata, 0);
        rst = 0;
        tick();
        chk("rst_mid_rel_ready", {arready, awready}, 2'b11);
        chk("rst_mid_rel_rvalid", rvalid, 0);
        axi_read(BASE + 32'h18, 4'd0, 3'd3, 2'b01, 6'h1A, 0);
        chk("rst_mid_ram3", rbuf[0], 64'd3);
        axi_read(BASE + 32'h38, 4'd0, 3'd3, 2'b01, 6'h1B, 0);
        chk("rst_mid_ram7", rbuf[0], 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
